// File: rtl/sram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_arb_pkg                                                 |
// | Description : Shared types and constants for the two-requester SRAM port   |
// |               arbiter: sequencer state encoding, requester id type and     |
// |               default geometry of the 16-bit SRAM port.                    |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_arb_pkg;

   // Default SRAM address width and the word offset between the upper and
   // lower 16-bit halves of one 32-bit transaction.
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_ADDR_STEP = 16;

   // Saturation value of the optional contention counter.
   localparam logic [15:0] CONFLICT_CNT_MAX = 16'hFFFF;

   // Each transaction walks the full sequence once; the explicit 3-bit
   // encoding keeps the register width fixed across tools.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP_HI  = 3'd1,
      ACCESS_HI = 3'd2,
      SETUP_LO  = 3'd3,
      ACCESS_LO = 3'd4,
      DONE      = 3'd5
   } arb_state_t;

   // Requester identifier: 0 = audio delay-line engine, 1 = debug/host.
   typedef logic req_id_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_arb_rr                                                  |
// | Description : Combinational two-way round-robin picker. A lone request is  |
// |               granted directly; when both requesters are asking, the one   |
// |               that was not granted last wins.                              |
// | Ports       : req0_i, req1_i  - request levels                             |
// |               last_grant_i    - id of the most recent grant                |
// |               grant_valid_o   - at least one request is pending            |
// |               grant_id_o      - id of the requester to grant               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_arb_rr
   import sram_arb_pkg::*;
(
   input  logic    req0_i,
   input  logic    req1_i,
   input  req_id_t last_grant_i,
   output logic    grant_valid_o,
   output req_id_t grant_id_o
);

   always_comb begin
      grant_valid_o = req0_i | req1_i;
      grant_id_o    = 1'b0;
      if (req0_i && req1_i) begin
         grant_id_o = ~last_grant_i;
      end else if (req1_i) begin
         grant_id_o = 1'b1;
      end
   end

endmodule : sram_arb_rr
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_port_arbiter                                            |
// | Description : Shares one 16-bit on-chip SRAM port between two 32-bit       |
// |               requesters (0 = audio delay-line engine, 1 = debug/host).    |
// |               Every 32-bit transaction is split into an upper and a lower  |
// |               16-bit half, each given a setup cycle and an access cycle,   |
// |               followed by a single-cycle ack. Round-robin arbitration.     |
// | Ports       : clk, n_rst            - clock, synchronous active-low reset  |
// |               reqN_i/weN_i/addrN_i/wdataN_i - requester N transaction      |
// |               ackN_o, rdataN_o      - completion pulse and read result     |
// |               sram_r_en_o, sram_w_en_o, sram_addr_o, sram_wdata_o,         |
// |               sram_rdata_i          - SRAM wrapper interface               |
// |               conflict_cnt_o        - contention counter (optional)        |
// | Options     : `define SRAM_ARB_STATS_EN adds conflict_cnt_o, a saturating  |
// |               count of IDLE cycles in which both requesters were asking.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int ADDR_STEP = DEF_ADDR_STEP
) (
   input  logic              clk,
   input  logic              n_rst,
   // requester 0
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [31:0]       wdata0_i,
   output logic              ack0_o,
   output logic [31:0]       rdata0_o,
   // requester 1
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [31:0]       wdata1_i,
   output logic              ack1_o,
   output logic [31:0]       rdata1_o,
   // SRAM wrapper
   output logic              sram_r_en_o,
   output logic              sram_w_en_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [15:0]       sram_wdata_o,
   input  logic [15:0]       sram_rdata_i
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]       conflict_cnt_o
`endif
);

   localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(ADDR_STEP);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   arb_state_t        state_q, state_d;
   req_id_t           last_grant_q, last_grant_d;
   req_id_t           id_q, id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [15:0]       rbuf_hi_q, rbuf_hi_d;
   logic [31:0]       rdata0_q, rdata0_d;
   logic [31:0]       rdata1_q, rdata1_d;

   logic              grant_valid;
   req_id_t           grant_id;
   logic [ADDR_W-1:0] addr_lo;

   // Lower half lives ADDR_STEP words above the base; the sum deliberately
   // wraps at ADDR_W bits.
   assign addr_lo = addr_q + STEP_C;

   sram_arb_rr u_rr (
      .req0_i        (req0_i),
      .req1_i        (req1_i),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   // ------------------------------------------------------------------------
   // Sequencer and datapath next-state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rbuf_hi_d    = rbuf_hi_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = SETUP_HI;
               last_grant_d = grant_id;
               id_d         = grant_id;
               we_d         = grant_id ? we1_i    : we0_i;
               addr_d       = grant_id ? addr1_i  : addr0_i;
               wdata_d      = grant_id ? wdata1_i : wdata0_i;
            end
         end
         SETUP_HI: state_d = ACCESS_HI;
         ACCESS_HI: begin
            state_d = SETUP_LO;
            if (!we_q) begin
               rbuf_hi_d = sram_rdata_i;
            end
         end
         SETUP_LO: state_d = ACCESS_LO;
         ACCESS_LO: begin
            state_d = DONE;
            // The lower half is merged straight into the requester's result
            // register so rdata is already valid while ack is high.
            if (!we_q) begin
               if (id_q) begin
                  rdata1_d = {rbuf_hi_q, sram_rdata_i};
               end else begin
                  rdata0_d = {rbuf_hi_q, sram_rdata_i};
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rbuf_hi_q    <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rbuf_hi_q    <= rbuf_hi_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode: everything is a function of registered state only, so the
   // SRAM controls and acks change exactly at clock edges.
   // ------------------------------------------------------------------------
   always_comb begin
      sram_r_en_o  = 1'b0;
      sram_w_en_o  = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      ack0_o       = 1'b0;
      ack1_o       = 1'b0;

      case (state_q)
         SETUP_HI: begin
            sram_addr_o  = addr_q;
            sram_wdata_o = we_q ? wdata_q[31:16] : 16'h0000;
         end
         ACCESS_HI: begin
            sram_addr_o  = addr_q;
            sram_w_en_o  = we_q;
            sram_r_en_o  = ~we_q;
            sram_wdata_o = we_q ? wdata_q[31:16] : 16'h0000;
         end
         SETUP_LO: begin
            sram_addr_o  = addr_lo;
            sram_wdata_o = we_q ? wdata_q[15:0] : 16'h0000;
         end
         ACCESS_LO: begin
            sram_addr_o  = addr_lo;
            sram_w_en_o  = we_q;
            sram_r_en_o  = ~we_q;
            sram_wdata_o = we_q ? wdata_q[15:0] : 16'h0000;
         end
         DONE: begin
            ack0_o = ~id_q;
            ack1_o = id_q;
         end
         default: begin
            sram_r_en_o = 1'b0;
         end
      endcase
   end

   assign rdata0_o = rdata0_q;
   assign rdata1_o = rdata1_q;

`ifdef SRAM_ARB_STATS_EN
   // ------------------------------------------------------------------------
   // Contention statistics: counts IDLE cycles where both requesters ask.
   // ------------------------------------------------------------------------
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if ((state_q == IDLE) && req0_i && req1_i &&
          (conflict_cnt_q != CONFLICT_CNT_MAX)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         conflict_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_port_arbiter                                         |
// | Description : Self-checking bench for sram_port_arbiter with a behavioural |
// |               SRAM and a transaction-level reference memory.              |
// |               Honours `define SRAM_ARB_STATS_EN for the counter port.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic        sram_r_en, sram_w_en;
   logic [15:0] sram_addr, sram_wdata, sram_rdata;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0] conflict_cnt;
   logic [15:0] ob_cc [0:31];
`endif

   int n_vec = 0;
   int n_err = 0;

   // Behavioural SRAM (what the DUT really touches) and the reference memory
   // (what the transaction model predicts).
   logic [15:0] sram_mem [0:65535];
   logic [15:0] ref_mem  [0:65535];

   // Observation buffers filled by observe()
   logic        ob_r [0:31], ob_w [0:31], ob_a0 [0:31], ob_a1 [0:31];
   logic [15:0] ob_addr [0:31], ob_wd [0:31];
   logic [31:0] ob_rd0 [0:31], ob_rd1 [0:31];

   always #5 clk = ~clk;

   assign sram_rdata = sram_mem[sram_addr];
   always @(posedge clk) if (sram_w_en) sram_mem[sram_addr] = sram_wdata;

   sram_port_arbiter #(.ADDR_W(16), .ADDR_STEP(16)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req0_i       (req0),
      .we0_i        (we0),
      .addr0_i      (addr0),
      .wdata0_i     (wdata0),
      .ack0_o       (ack0),
      .rdata0_o     (rdata0),
      .req1_i       (req1),
      .we1_i        (we1),
      .addr1_i      (addr1),
      .wdata1_i     (wdata1),
      .ack1_o       (ack1),
      .rdata1_o     (rdata1),
      .sram_r_en_o  (sram_r_en),
      .sram_w_en_o  (sram_w_en),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_rdata_i (sram_rdata)
`ifdef SRAM_ARB_STATS_EN
      ,
      .conflict_cnt_o (conflict_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records n cycles of outputs (cycle 0 = the cycle requests are first
   // presented). Unless keep is set, a requester drops req when acked.
   task automatic observe(input int n, input bit keep);
      for (int c = 0; c < n; c++) begin
         ob_r[c] = sram_r_en;  ob_w[c] = sram_w_en;
         ob_addr[c] = sram_addr; ob_wd[c] = sram_wdata;
         ob_a0[c] = ack0; ob_a1[c] = ack1;
         ob_rd0[c] = rdata0; ob_rd1[c] = rdata1;
`ifdef SRAM_ARB_STATS_EN
         ob_cc[c] = conflict_cnt;
`endif
         if (!keep) begin
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) tick();
      n_rst = 1'b1;
      tick();
      n_vec++; if ({sram_r_en, sram_w_en, ack0, ack1} !== 4'b0) begin n_err++;
         $display("FAIL reset_ctl: got %b want 0000", {sram_r_en, sram_w_en, ack0, ack1}); end
      n_vec++; if ({sram_addr, sram_wdata} !== 32'h0) begin n_err++;
         $display("FAIL reset_bus: got %h want 0", {sram_addr, sram_wdata}); end
      n_vec++; if ({rdata0, rdata1} !== 64'h0) begin n_err++;
         $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1}); end
`ifdef SRAM_ARB_STATS_EN
      n_vec++; if (conflict_cnt !== 16'h0) begin n_err++;
         $display("FAIL reset_cc: got %h want 0", conflict_cnt); end
`endif
   endtask

   task automatic test_contention();
      n_rst = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0100; wdata0 = 32'h1111_2222;
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 32'h3333_4444;
      repeat (2) tick();
      n_rst = 1'b1;
      observe(24, 1'b1);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      ref_mem[16'h0100] = 16'h1111; ref_mem[16'h0110] = 16'h2222;
      ref_mem[16'h0200] = 16'h3333; ref_mem[16'h0210] = 16'h4444;
      for (int c = 0; c < 24; c++) begin
         n_vec++; if (ob_a0[c] !== (c == 5 || c == 17)) begin n_err++;
            $display("FAIL cont_ack0 c%0d: got %b want %b", c, ob_a0[c], (c == 5 || c == 17)); end
         n_vec++; if (ob_a1[c] !== (c == 11 || c == 23)) begin n_err++;
            $display("FAIL cont_ack1 c%0d: got %b want %b", c, ob_a1[c], (c == 11 || c == 23)); end
         if (c % 6 == 2) begin
            n_vec++; if (ob_addr[c] !== ((c % 12 == 2) ? 16'h0100 : 16'h0200)) begin n_err++;
               $display("FAIL cont_order c%0d: got %h want %h", c, ob_addr[c],
                        ((c % 12 == 2) ? 16'h0100 : 16'h0200)); end
         end
      end
      n_vec++; if (sram_mem[16'h0210] !== 16'h4444) begin n_err++;
         $display("FAIL cont_mem: got %h want 4444", sram_mem[16'h0210]); end
`ifdef SRAM_ARB_STATS_EN
      n_vec++; if (ob_cc[0] !== 16'd0) begin n_err++; $display("FAIL cc0: got %0d want 0", ob_cc[0]); end
      n_vec++; if (ob_cc[1] !== 16'd1) begin n_err++; $display("FAIL cc1: got %0d want 1", ob_cc[1]); end
      n_vec++; if (ob_cc[7] !== 16'd2) begin n_err++; $display("FAIL cc7: got %0d want 2", ob_cc[7]); end
      n_vec++; if (ob_cc[23] !== 16'd4) begin n_err++; $display("FAIL cc23: got %0d want 4", ob_cc[23]); end
`endif
   endtask

   task automatic test_write();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 32'hDEAD_BEEF;
      observe(7, 1'b0);
      ref_mem[16'h0010] = 16'hDEAD; ref_mem[16'h0020] = 16'hBEEF;
      for (int c = 0; c < 7; c++) begin
         n_vec++; if (ob_w[c] !== (c == 2 || c == 4) || ob_r[c] !== 1'b0) begin n_err++;
            $display("FAIL wr_en c%0d: got w%b r%b want w%b r0", c, ob_w[c], ob_r[c], (c == 2 || c == 4)); end
         n_vec++; if (ob_a0[c] !== (c == 5) || ob_a1[c] !== 1'b0) begin n_err++;
            $display("FAIL wr_ack c%0d: got %b%b want %b0", c, ob_a0[c], ob_a1[c], (c == 5)); end
      end
      n_vec++; if ({ob_addr[2], ob_wd[2]} !== 32'h0010_DEAD) begin n_err++;
         $display("FAIL wr_hi: got %h want 0010dead", {ob_addr[2], ob_wd[2]}); end
      n_vec++; if ({ob_addr[4], ob_wd[4]} !== 32'h0020_BEEF) begin n_err++;
         $display("FAIL wr_lo: got %h want 0020beef", {ob_addr[4], ob_wd[4]}); end
      n_vec++; if ({sram_mem[16'h0010], sram_mem[16'h0020]} !== 32'hDEAD_BEEF) begin n_err++;
         $display("FAIL wr_mem: got %h want deadbeef", {sram_mem[16'h0010], sram_mem[16'h0020]}); end
   endtask

   task automatic test_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 32'h5555_AAAA;
      observe(7, 1'b0);
      for (int c = 0; c < 7; c++) begin
         n_vec++; if (ob_r[c] !== (c == 2 || c == 4) || ob_w[c] !== 1'b0) begin n_err++;
            $display("FAIL rd_en c%0d: got r%b w%b want r%b w0", c, ob_r[c], ob_w[c], (c == 2 || c == 4)); end
      end
      n_vec++; if (ob_wd[2] !== 16'h0) begin n_err++; $display("FAIL rd_wdata: got %h want 0", ob_wd[2]); end
      n_vec++; if (ob_rd0[4] !== 32'h0) begin n_err++; $display("FAIL rd_early: got %h want 0", ob_rd0[4]); end
      n_vec++; if (ob_a0[5] !== 1'b1 || ob_rd0[5] !== 32'hDEAD_BEEF) begin n_err++;
         $display("FAIL rd_data: got ack%b %h want ack1 deadbeef", ob_a0[5], ob_rd0[5]); end
      n_vec++; if (ob_rd1[5] !== 32'h0) begin n_err++; $display("FAIL rd_other: got %h want 0", ob_rd1[5]); end
   endtask

   task automatic test_wrap();
      sram_mem[16'hFFF8] = 16'h1234; ref_mem[16'hFFF8] = 16'h1234;
      sram_mem[16'h0008] = 16'h5678; ref_mem[16'h0008] = 16'h5678;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'hFFF8;
      observe(7, 1'b0);
      n_vec++; if (ob_addr[2] !== 16'hFFF8 || ob_r[2] !== 1'b1) begin n_err++;
         $display("FAIL wrap_hi: got %h r%b want fff8 r1", ob_addr[2], ob_r[2]); end
      n_vec++; if (ob_addr[4] !== 16'h0008 || ob_r[4] !== 1'b1) begin n_err++;
         $display("FAIL wrap_lo: got %h r%b want 0008 r1", ob_addr[4], ob_r[4]); end
      n_vec++; if (ob_a1[5] !== 1'b1 || ob_a0[5] !== 1'b0 || ob_rd1[5] !== 32'h1234_5678) begin n_err++;
         $display("FAIL wrap_data: got ack%b%b %h want ack01 12345678", ob_a0[5], ob_a1[5], ob_rd1[5]); end
      n_vec++; if (ob_rd0[5] !== 32'hDEAD_BEEF) begin n_err++;
         $display("FAIL wrap_other: got %h want deadbeef", ob_rd0[5]); end
   endtask

   task automatic test_reset_mid();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0300; wdata0 = 32'hCAFE_F00D;
      tick(); tick();
      n_vec++; if (sram_w_en !== 1'b1 || sram_addr !== 16'h0300) begin n_err++;
         $display("FAIL rstm_access: got w%b %h want w1 0300", sram_w_en, sram_addr); end
      n_rst = 1'b0;
      tick();
      req0 = 1'b0;
      n_vec++; if ({sram_r_en, sram_w_en, ack0, ack1} !== 4'b0 || {sram_addr, sram_wdata} !== 32'h0) begin n_err++;
         $display("FAIL rstm_out: got %b %h want 0", {sram_r_en, sram_w_en, ack0, ack1}, {sram_addr, sram_wdata}); end
      n_vec++; if ({rdata0, rdata1} !== 64'h0) begin n_err++;
         $display("FAIL rstm_rdata: got %h want 0", {rdata0, rdata1}); end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 1) n_rst = 1'b1;
         n_vec++; if ({sram_r_en, sram_w_en, ack0, ack1} !== 4'b0) begin n_err++;
            $display("FAIL rstm_quiet c%0d: got %b want 0000", c, {sram_r_en, sram_w_en, ack0, ack1}); end
      end
      n_vec++; if (sram_mem[16'h0300] !== 16'hCAFE || sram_mem[16'h0310] !== ref_mem[16'h0310]) begin n_err++;
         $display("FAIL rstm_mem: got %h %h want cafe %h", sram_mem[16'h0300], sram_mem[16'h0310], ref_mem[16'h0310]); end
      ref_mem[16'h0300] = 16'hCAFE;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      exp = {ref_mem[16'h0010], ref_mem[16'h0020]};
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      observe(12, 1'b1);
      req0 = 1'b0;
      tick();
      for (int c = 0; c < 12; c++) begin
         n_vec++; if (ob_a0[c] !== (c == 5 || c == 11) || ob_a1[c] !== 1'b0) begin n_err++;
            $display("FAIL b2b_ack c%0d: got %b%b want %b0", c, ob_a0[c], ob_a1[c], (c == 5 || c == 11)); end
         n_vec++; if (ob_r[c] !== (c == 2 || c == 4 || c == 8 || c == 10)) begin n_err++;
            $display("FAIL b2b_ren c%0d: got %b", c, ob_r[c]); end
      end
      n_vec++; if (ob_rd0[4] !== 32'h0 || ob_rd0[5] !== exp || ob_rd0[11] !== exp) begin n_err++;
         $display("FAIL b2b_data: got %h %h %h want 0 %h %h", ob_rd0[4], ob_rd0[5], ob_rd0[11], exp, exp); end
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 5))
         0:       return 16'h0010;
         1:       return 16'h0020;
         2:       return 16'hFFF8;
         3:       return 16'h0008;
         4:       return 16'h0400;
         default: return 16'($urandom);
      endcase
   endfunction

   // Transaction-level model: the port is busy for 6 cycles after each grant,
   // contended grants alternate, writes update ref_mem at grant time.
   task automatic test_random();
      int          g = -100;
      int          busy_until = 0;
      int          done = 0;
      bit          gid = 1'b0, gwe = 1'b0, lg = 1'b0;
      logic [15:0] ga = 16'h0, ga2 = 16'h0;
      logic [31:0] gwd = 32'h0, gexp = 32'h0;
      logic [31:0] er0, er1;
      logic        en;
      er0 = {ref_mem[16'h0010], ref_mem[16'h0020]};
      er1 = 32'h0;
      for (int cyc = 0; cyc < 4000 && done < 60; cyc++) begin
         en = (cyc == g + 2) || (cyc == g + 4);
         if (cyc == g + 5 && !gwe) begin
            if (gid) er1 = gexp; else er0 = gexp;
         end
         n_vec++; if (ack0 !== (cyc == g + 5 && !gid) || ack1 !== (cyc == g + 5 && gid)) begin n_err++;
            $display("FAIL rnd_ack cyc%0d: got %b%b want %b%b", cyc, ack0, ack1,
                     (cyc == g + 5 && !gid), (cyc == g + 5 && gid)); end
         n_vec++; if (sram_r_en !== (en && !gwe) || sram_w_en !== (en && gwe)) begin n_err++;
            $display("FAIL rnd_en cyc%0d: got r%b w%b want r%b w%b", cyc, sram_r_en, sram_w_en,
                     (en && !gwe), (en && gwe)); end
         if (en) begin
            n_vec++; if (sram_addr !== ((cyc == g + 2) ? ga : ga2)) begin n_err++;
               $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, sram_addr, ((cyc == g + 2) ? ga : ga2)); end
            if (gwe) begin
               n_vec++; if (sram_wdata !== ((cyc == g + 2) ? gwd[31:16] : gwd[15:0])) begin n_err++;
                  $display("FAIL rnd_wdata cyc%0d: got %h", cyc, sram_wdata); end
            end
         end
         n_vec++; if (rdata0 !== er0 || rdata1 !== er1) begin n_err++;
            $display("FAIL rnd_rdata cyc%0d: got %h %h want %h %h", cyc, rdata0, rdata1, er0, er1); end
         if (cyc == g + 5) begin
            done++;
            if (gid) req1 = 1'b0; else req0 = 1'b0;
         end
         if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; we0 = 1'($urandom); addr0 = pick_addr(); wdata0 = $urandom;
         end
         if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; we1 = 1'($urandom); addr1 = pick_addr(); wdata1 = $urandom;
         end
         if (cyc >= busy_until && (req0 || req1)) begin
            gid = (req0 && req1) ? !lg : req1;
            lg  = gid;
            g   = cyc;
            busy_until = cyc + 6;
            gwe = gid ? we1 : we0;
            ga  = gid ? addr1 : addr0;
            gwd = gid ? wdata1 : wdata0;
            ga2 = ga + 16'd16;
            if (gwe) begin
               ref_mem[ga] = gwd[31:16];
               ref_mem[ga2] = gwd[15:0];
            end else begin
               gexp = {ref_mem[ga], ref_mem[ga2]};
            end
         end
         tick();
      end
      n_vec++; if (done < 60) begin n_err++;
         $display("FAIL rnd_timeout: got %0d transactions want 60", done); end
      req0 = 1'b0; req1 = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      logic [15:0] v;
      n_rst = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 32'h0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 32'h0;
      for (int i = 0; i < 65536; i++) begin
         v = 16'($urandom);
         sram_mem[i] = v;
         ref_mem[i]  = v;
      end
      test_reset();
      test_contention();
      test_write();
      test_read();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sram_port_arbiter
`default_nettype wire
